full_adder: RTL and testbench

- Registered 1-bit full adder, parameterizable to an N-bit ripple-carry adder.
- Computes sum = a ^ b ^ cin and cout = majority(a, b, cin) per bit position.
- Outputs are captured in a single pipeline register stage with a valid flag.
- Arithmetic leaf used by wider datapath adders and by the adder characterization benches.

---
 rtl/adder_pkg.sv | 15 +
 rtl/fa_cell.sv | 18 +
 rtl/full_adder.sv | 71 +++++++
 tb/tb_full_adder.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared constants, result type and bit-level helper for the adder slice
package adder_pkg;

    localparam int DEFAULT_WIDTH = 1;

    typedef struct packed {
        logic cout;
        logic sum;
    } bit_res_t;

    function automatic bit_res_t fa_eval(input logic a, input logic b, input logic c);
        return '{cout: (a & b) | (a & c) | (b & c), sum: a ^ b ^ c};
    endfunction

endpackage

// File: rtl/fa_cell.sv
// fa_cell: combinational 1-bit full adder, one link of the ripple chain
module fa_cell
    import adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    bit_res_t r;

    assign r    = fa_eval(a, b, cin);
    assign sum  = r.sum;
    assign cout = r.cout;

endmodule

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder with optional output register and valid flag
module full_adder
    import adder_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    typedef struct packed {
        logic             cout;
        logic [WIDTH-1:0] sum;
    } res_t;

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    res_t             comb_res;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        fa_cell u_cell (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .sum (s[i]),
            .cout(c[i+1])
        );
    end

    assign comb_res = '{cout: c[WIDTH], sum: s};

    if (REG_OUT) begin : g_reg
        res_t res_d, res_q;
        logic valid_d, valid_q;
        // capture a new result only when operands are valid; otherwise hold it
        always_comb begin
            res_d   = in_valid ? comb_res : res_q;
            valid_d = in_valid;
        end
        // output pipeline stage; reset discards any pending result immediately
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                res_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                res_q   <= res_d;
                valid_q <= valid_d;
            end
        end
        assign sum       = res_q.sum;
        assign cout      = res_q.cout;
        assign out_valid = valid_q;
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign sum            = comb_res.sum;
        assign cout           = comb_res.cout;
        assign out_valid      = in_valid;
    end

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed checks of registered 1-bit, registered 8-bit and combinational adders
module tb_full_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [0:0] a1 = '0, b1 = '0, s1;
    logic       c1 = 1'b0, v1 = 1'b0, co1, ov1;

    logic [7:0] a8 = '0, b8 = '0, s8;
    logic       c8 = 1'b0, v8 = 1'b0, co8, ov8;

    logic [0:0] a0 = '0, b0 = '0, s0;
    logic       c0 = 1'b0, v0 = 1'b0, co0, ov0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(c1), .in_valid(v1),
        .sum(s1), .cout(co1), .out_valid(ov1)
    );

    full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(c8), .in_valid(v8),
        .sum(s8), .cout(co8), .out_valid(ov8)
    );

    full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u0 (
        .clk(clk), .rst(rst), .a(a0), .b(b0), .cin(c0), .in_valid(v0),
        .sum(s0), .cout(co0), .out_valid(ov0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {a, b, cin, sum, cout} with hand-computed results
    logic [4:0] tt [8] = '{
        5'b000_00, 5'b001_10, 5'b010_10, 5'b100_10,
        5'b011_01, 5'b110_01, 5'b101_01, 5'b111_11
    };

    initial begin
        logic [8:0] exp9;
        logic [4:0] v;
        // reset state
        #2;
        check("rst_s1", 32'(s1), 0);
        check("rst_c1", 32'(co1), 0);
        check("rst_v1", 32'(ov1), 0);
        check("rst_s8", 32'(s8), 0);
        check("rst_v8", 32'(ov8), 0);
        #10 rst = 1'b0;
        // exhaustive 1-bit truth table, one vector per cycle
        for (int i = 0; i < 8; i++) begin
            v = tt[i];
            a1 = v[4]; b1 = v[3]; c1 = v[2]; v1 = 1'b1;
            @(posedge clk); #1;
            check($sformatf("tt%0d_sum", i), 32'(s1), 32'(v[1]));
            check($sformatf("tt%0d_cout", i), 32'(co1), 32'(v[0]));
            check($sformatf("tt%0d_valid", i), 32'(ov1), 1);
        end
        // asynchronous reset between edges while sum=1, cout=1
        #2 rst = 1'b1;
        #1;
        check("arst_sum", 32'(s1), 0);
        check("arst_cout", 32'(co1), 0);
        check("arst_valid", 32'(ov1), 0);
        @(posedge clk); #1;
        check("arst_hold_sum", 32'(s1), 0);
        check("arst_hold_valid", 32'(ov1), 0);
        #2 rst = 1'b0;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
        @(posedge clk); #1;
        check("post_rst_sum", 32'(s1), 1);
        check("post_rst_cout", 32'(co1), 1);
        check("post_rst_valid", 32'(ov1), 1);
        // valid gating: operands change, result holds, valid drops
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        @(posedge clk); #1;
        check("gate0_valid", 32'(ov1), 0);
        check("gate0_sum", 32'(s1), 1);
        check("gate0_cout", 32'(co1), 1);
        b1 = 1'b1;
        @(posedge clk); #1;
        check("gate1_valid", 32'(ov1), 0);
        check("gate1_sum", 32'(s1), 1);
        check("gate1_cout", 32'(co1), 1);
        // 8-bit carry chain
        a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; v8 = 1'b1;
        @(posedge clk); #1;
        check("w8_ff00_sum", 32'(s8), 32'h00);
        check("w8_ff00_cout", 32'(co8), 1);
        check("w8_ff00_valid", 32'(ov8), 1);
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        @(posedge clk); #1;
        check("w8_ffff_sum", 32'(s8), 32'hFF);
        check("w8_ffff_cout", 32'(co8), 1);
        a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        @(posedge clk); #1;
        check("w8_zero_sum", 32'(s8), 0);
        check("w8_zero_cout", 32'(co8), 0);
        a8 = 8'h5A; b8 = 8'h3C; c8 = 1'b0;
        @(posedge clk); #1;
        check("w8_5a3c_sum", 32'(s8), 32'h96);
        check("w8_5a3c_cout", 32'(co8), 0);
        // 8-bit random back-to-back vectors
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            c8 = 1'($urandom);
            exp9 = {1'b0, a8} + {1'b0, b8} + {8'b0, c8};
            @(posedge clk); #1;
            check($sformatf("rnd%0d", i), 32'({ov8, co8, s8}), 32'({1'b1, exp9}));
        end
        v8 = 1'b0;
        @(posedge clk); #1;
        check("w8_drop_valid", 32'(ov8), 0);
        // combinational variant: results settle in the same cycle
        for (int i = 0; i < 8; i++) begin
            v = tt[i];
            a0 = v[4]; b0 = v[3]; c0 = v[2]; v0 = i[0];
            #1;
            check($sformatf("comb%0d_sum", i), 32'(s0), 32'(v[1]));
            check($sformatf("comb%0d_cout", i), 32'(co0), 32'(v[0]));
            check($sformatf("comb%0d_valid", i), 32'(ov0), 32'(i[0]));
            #9;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
